// File: rtl/ex_muldiv.sv
// RV32M multiply/divide beside the EX ALU: array (latency 1) or shift-add (XLEN+1) multiply, restoring divide (XLEN+1).
// Holds the pipeline while busy; one-cycle valid_o pulse in DONE, suppressed by flush_i.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_ITER = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            valid_o,
  output logic            hold_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic ARRAY_MUL = (MUL_ITER == 0);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic              neg_q, rneg_q;
  logic [CW-1:0]     cnt;
  logic              cooldown;

  logic              s1, s2, is_div, div_zero, div_ovf, accept, last;
  logic [XLEN-1:0]   mag1, mag2, res_direct;
  logic [2*XLEN-1:0] prod_direct, acc_step;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;

  // Sign fix-up: products are negated on the full double width before selecting a half.
  function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic [2*XLEN-1:0] v,
                                            input logic qneg, input logic rneg);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    p = qneg ? -v : v;
    r = '0;
    case (op)
      3'b000:                 r = p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: r = p[2*XLEN-1:XLEN];
      3'b100, 3'b101:         r = qneg ? -v[XLEN-1:0] : v[XLEN-1:0];
      default:                r = rneg ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
    endcase
    return r;
  endfunction

  always_comb begin
    s1       = ((op_i == 3'b001) | (op_i == 3'b010) | (op_i == 3'b100) | (op_i == 3'b110)) & op1_i[XLEN-1];
    s2       = ((op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110)) & op2_i[XLEN-1];
    mag1     = s1 ? -op1_i : op1_i;
    mag2     = s2 ? -op2_i : op2_i;
    is_div   = op_i[2];
    div_zero = is_div & (op2_i == '0);
    div_ovf  = is_div & ~op_i[0] & (op1_i == MIN_VAL) & (op2_i == '1);
    accept   = (state == IDLE) & start_i & ~flush_i & ~cooldown;
    last     = (cnt == CW'(XLEN - 1));
  end

  generate
    if (MUL_ITER == 0) begin : g_array
      assign prod_direct = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    end else begin : g_iter
      assign prod_direct = '0;
    end
  endgenerate

  always_comb begin
    if (div_zero)     res_direct = op_i[1] ? op1_i : '1;
    else if (div_ovf) res_direct = op_i[1] ? '0 : MIN_VAL;
    else              res_direct = fixup(op_i, prod_direct, s1 ^ s2, s1);
  end

  // acc holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, opb});
    div_diff  = div_shift[XLEN-1:0] - opb;
    if (state == MUL)
      acc_step = {mul_sum, acc[XLEN-1:1]};
    else
      acc_step = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (div_zero | div_ovf | (~is_div & ARRAY_MUL)) state_nxt = DONE;
          else if (~is_div)                                state_nxt = MUL;
          else                                             state_nxt = DIV;
        end
      end
      MUL, DIV: if (last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      acc       <= '0;
      opb       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      cnt       <= '0;
      cooldown  <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else begin
      // The instruction that just completed is still held in EX for one more cycle.
      cooldown <= (state == DONE) & ~flush_i;
      if (accept) begin
        op_q      <= op_i;
        opb       <= mag2;
        neg_q     <= s1 ^ s2;
        rneg_q    <= s1;
        cnt       <= '0;
        acc       <= {{XLEN{1'b0}}, mag1};
        rd_addr_o <= rd_addr_i;
        result_o  <= res_direct;
      end else if ((state == MUL) || (state == DIV)) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
        if (last) result_o <= fixup(op_q, acc_step, neg_q, rneg_q);
      end
    end
  end

  assign valid_o = (state == DONE) & ~flush_i;
  assign hold_o  = rst_n & (((state == IDLE) & start_i & ~flush_i) | (state == MUL) | (state == DIV));

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
RV32M multiply/divide unit attached beside the execute stage ALU. It accepts one M-extension operation (opcode 0110011, funct7 0000001) with forwarded operands. It produces the result after a fixed, parameter-dependent latency. While the operation runs, it asserts hold so the control unit stalls IF/ID/EX. It is parametrised in data width and multiplier implementation, and supports flush and divide special cases.

Parameters:
XLEN, 32, operand/result width (>=8, even)
MUL_ITER, 0, 0 = single-cycle array multiply (registered, latency 1); 1 = iterative shift-add multiply (XLEN cycles)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  EX holds a valid M-extension instruction (level, held while stalled)
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  input  XLEN  rs1 value, already forwarded
op2_i  input  XLEN  rs2 value, already forwarded
rd_addr_i  input  5  destination register
flush_i  input  1  jump/flush from control; aborts the operation in flight
result_o  output  XLEN  result, registered
rd_addr_o  output  5  destination register of result
valid_o  output  1  one-cycle pulse: result_o/rd_addr_o valid, EX writes back
hold_o  output  1  stall request to control (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - result_o=0, rd_addr_o=0, valid_o=0
  - all internal counters/accumulators cleared
  - hold_o=0 while in reset
- States:
  - IDLE: accepts start_i; captures op, operands and rd_addr.
    - Multiply with MUL_ITER=0 -> DONE.
    - DIV/REM with op2==0 -> DONE.
    - Signed DIV/REM with op1==min and op2==-1 -> DONE.
    - MUL* with MUL_ITER=1 -> MUL.
    - Otherwise -> DIV.
  - MUL: shift-add over 2*XLEN-bit product of sign-adjusted magnitudes. Counter runs XLEN cycles, then -> DONE.
  - DIV: restoring radix-2 on absolute values, one quotient bit per cycle. Counter runs XLEN cycles, then -> DONE.
  - DONE: applies sign fix-up, drives result_o and valid_o=1 for exactly one cycle, then -> IDLE.
- Latency (start accepted at cycle 0):
  - valid_o at cycle 1 for MUL_ITER=0 multiplies and for divide special cases.
  - valid_o at cycle XLEN+1 for iterative ops.
- hold_o = (state==IDLE & start_i & !flush_i) | (state==MUL) | (state==DIV). hold_o is 0 in DONE, so the pipeline advances in the valid_o cycle.
- After DONE, start_i is ignored for one cycle. This prevents re-issuing the same held instruction.
- Operand signs:
  - MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Result selection:
  - MUL returns the low XLEN bits of the product.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - Product negation is applied on the full 2*XLEN width.
- Divide rules:
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - Divide by zero: quotient = all ones; remainder = op1.
  - Signed overflow (min / -1): quotient = min; remainder = 0.
- x0 destination: the operation executes normally and rd_addr_o=0 is passed through. Writeback logic discards it.
- flush_i:
  - Any state -> IDLE on the next edge. No valid_o is produced.
  - A flush in DONE suppresses valid_o in that same cycle (valid_o gated combinationally by !flush_i).
  - A flush in IDLE with start_i asserted prevents capture.
- start_i while in MUL/DIV: ignored; operands stay latched.
- Reset asserted mid-operation: immediate return to IDLE; no partial result escapes.

Test Plan:
- MUL_ITER=0, XLEN=32, expected values:
  - MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB
  - MULH 0x80000000 * 0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF
  - Each has valid_o at cycle 1 and hold_o high in cycle 0 only.
- MUL_ITER=1: the same vectors give identical results, with valid_o at cycle 33 and hold_o high in cycles 0..32.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14 and REMU -> 2. Each has valid_o at cycle 33, rd_addr_o equal to the captured rd_addr_i, and exactly one valid pulse.
- Special cases:
  - DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - Each has valid_o at cycle 1.
- Flush and reset:
  - Flush in DIV at cycle 10: no valid_o, hold_o low from cycle 11, and a new DIVU 9 / 3 started at cycle 12 yields 3 at cycle 45.
  - rst_n pulsed low mid-MUL: all outputs read 0 immediately.
- Held start_i kept high across the valid_o cycle and the following cycle: only one result is produced, then a fresh start is accepted on the second cycle after DONE.
